// File: rtl/mat_reg_streamer_pkg.sv
// Shared matrix-register types: read command encodings and the data word type.
package mat_reg_streamer_pkg;

    typedef enum logic [1:0] {
        MAT_DATA_READ_DISABLE = 2'd0,
        MAT_DATA_READ_ROW     = 2'd1,
        MAT_DATA_READ_COL     = 2'd2
    } MatDataReadOp_t;

    // Matrix elements are carried as IEEE-754 single-precision bit patterns.
    localparam int unsigned MAT_WORD_W = 32;
    typedef logic [MAT_WORD_W-1:0] mat_word_t;

endpackage

// File: rtl/mat_reg_streamer.sv
// Streams a run of rows or columns out of the matrix register, one vector per
// cycle, behind a valid/ready output slot.
module mat_reg_streamer
    import mat_reg_streamer_pkg::*;
#(
    parameter int unsigned WIDTH           = 128,
    parameter int unsigned WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic                                    col_mode,
    input  logic [WIDTH_ADDR_SIZE-1:0]              base,
    input  logic [WIDTH_ADDR_SIZE:0]                count,
    output MatDataReadOp_t                          read_op,
    output logic [WIDTH_ADDR_SIZE-1:0]              read_param1,
    output logic [WIDTH_ADDR_SIZE-1:0]              read_param2,
    input  logic [WIDTH-1:0][MAT_WORD_W-1:0]        rd_data,
    output logic [WIDTH-1:0][MAT_WORD_W-1:0]        out_data,
    output logic [WIDTH_ADDR_SIZE-1:0]              out_index,
    output logic                                    out_last,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    done
);

    localparam int unsigned AW = WIDTH_ADDR_SIZE;
    localparam int unsigned CW = WIDTH_ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                            state_q, state_d;
    logic                              mode_q, mode_d;
    logic [AW-1:0]                     base_q, base_d;
    logic [CW-1:0]                     count_q, count_d;
    logic [CW-1:0]                     k_q, k_d;
    logic                              valid_q, valid_d;
    logic                              last_q, last_d;
    logic                              done_q, done_d;
    logic [AW-1:0]                     index_q, index_d;
    logic [WIDTH-1:0][MAT_WORD_W-1:0]  data_q, data_d;

    logic [CW-1:0] count_clamped;
    logic [CW-1:0] idx_sum;
    logic [AW-1:0] idx;
    logic          issue;
    logic          is_last;

    // (base + k) mod WIDTH; both operands are below WIDTH so one subtract suffices.
    always_comb begin
        count_clamped = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;
        idx_sum       = {1'b0, base_q} + {1'b0, k_q[AW-1:0]};
        idx           = (idx_sum >= CW'(WIDTH)) ? AW'(idx_sum - CW'(WIDTH)) : AW'(idx_sum);
        issue         = (state_q == STREAM) && (!valid_q || out_ready);
        is_last       = (k_q == count_q - CW'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            count_q <= count_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        count_d     = count_q;
        k_d         = k_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        index_d     = index_q;
        data_d      = data_q;
        read_op     = MAT_DATA_READ_DISABLE;
        read_param1 = '0;

        // A completed beat frees the slot unless a new read refills it below.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d  = col_mode;
                        base_d  = base;
                        count_d = count_clamped;
                        k_d     = '0;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (issue) begin
                    read_op     = mode_q ? MAT_DATA_READ_COL : MAT_DATA_READ_ROW;
                    read_param1 = idx;
                    data_d      = rd_data;
                    valid_d     = 1'b1;
                    index_d     = idx;
                    last_d      = is_last;
                    k_d         = k_q + CW'(1);
                    if (is_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign read_param2 = '0;
    assign out_data    = data_q;
    assign out_index   = index_q;
    assign out_last    = last_q;
    assign out_valid   = valid_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_mat_reg_streamer.sv
// Directed bench for mat_reg_streamer against a combinational matrix-register model.
module tb_mat_reg_streamer;
    import mat_reg_streamer_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = $clog2(W);
    localparam int unsigned VW = W * 32;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic                   col_mode;
    logic [AW-1:0]          base;
    logic [AW:0]            count;
    MatDataReadOp_t         read_op;
    logic [AW-1:0]          read_param1;
    logic [AW-1:0]          read_param2;
    logic [W-1:0][31:0]     rd_data;
    logic [W-1:0][31:0]     out_data;
    logic [AW-1:0]          out_index;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    int n_pass  = 0;
    int n_total = 0;

    mat_reg_streamer #(.WIDTH(W), .WIDTH_ADDR_SIZE(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .col_mode(col_mode),
        .base(base), .count(count), .read_op(read_op), .read_param1(read_param1),
        .read_param2(read_param2), .rd_data(rd_data), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Matrix register model: m[i][j] = i*W + j.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < W; j++) begin
            if (read_op == MAT_DATA_READ_ROW)
                rd_data[j] = 32'(32'(read_param1) * W + 32'(j));
            else if (read_op == MAT_DATA_READ_COL)
                rd_data[j] = 32'(32'(j) * W + 32'(read_param1));
        end
    end

    function automatic logic [VW-1:0] row_vec(input int i);
        logic [W-1:0][31:0] v;
        for (int j = 0; j < W; j++) v[j] = 32'(i * W + j);
        return v;
    endfunction

    function automatic logic [VW-1:0] col_vec(input int c);
        logic [W-1:0][31:0] v;
        for (int i = 0; i < W; i++) v[i] = 32'(i * W + c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic cm, input int b, input int c);
        start    = 1'b1;
        col_mode = cm;
        base     = AW'(b);
        count    = (AW+1)'(c);
        tick();
        start    = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input int idx, input logic last, input logic cm);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk_vec({tag, "_data"}, out_data, cm ? col_vec(idx) : row_vec(idx));
    endtask

    initial begin
        int beats;
        int last_idx;
        bit seen_done;

        reset_n = 1'b0; start = 1'b0; col_mode = 1'b0; base = '0; count = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_op",    32'(read_op), 32'(MAT_DATA_READ_DISABLE));
        chk("rst_idx",   32'(out_index), 32'd0);
        reset_n = 1'b1;
        tick();

        // Row stream base=2 count=3
        launch(1'b0, 2, 3);
        chk("row_busy",  32'(busy), 32'd1);
        chk("row_nv",    32'(out_valid), 32'd0);
        chk("row_op",    32'(read_op), 32'(MAT_DATA_READ_ROW));
        chk("row_p1",    32'(read_param1), 32'd2);
        chk("row_p2",    32'(read_param2), 32'd0);
        tick(); expect_beat("row0", 2, 1'b0, 1'b0); chk("row0_done", 32'(done), 32'd0);
        tick(); expect_beat("row1", 3, 1'b0, 1'b0);
        tick(); expect_beat("row2", 4, 1'b1, 1'b0); chk("row2_done", 32'(done), 32'd0);
        tick();
        chk("row_done",   32'(done), 32'd1);
        chk("row_dvalid", 32'(out_valid), 32'd0);
        chk("row_idle",   32'(busy), 32'd0);
        tick();
        chk("row_done_pulse", 32'(done), 32'd0);

        // Column stream wrapping past W-1
        launch(1'b1, W - 2, 4);
        chk("col_op", 32'(read_op), 32'(MAT_DATA_READ_COL));
        tick(); expect_beat("col0", W - 2, 1'b0, 1'b1);
        tick(); expect_beat("col1", W - 1, 1'b0, 1'b1);
        tick(); expect_beat("col2", 0, 1'b0, 1'b1);
        tick(); expect_beat("col3", 1, 1'b1, 1'b1);
        tick(); chk("col_done", 32'(done), 32'd1);
        tick();

        // Backpressure: hold the first beat for five cycles
        out_ready = 1'b0;
        launch(1'b0, 0, 2);
        tick(); expect_beat("bp_first", 0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_op", 32'(read_op), 32'(MAT_DATA_READ_DISABLE));
            tick();
            expect_beat("bp_hold", 0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_op", 32'(read_op), 32'(MAT_DATA_READ_ROW));
        chk("bp_rel_p1", 32'(read_param1), 32'd1);
        tick(); expect_beat("bp_second", 1, 1'b1, 1'b0);
        tick();
        chk("bp_done",  32'(done), 32'd1);
        chk("bp_empty", 32'(out_valid), 32'd0);
        tick();

        // count=0: no beats, done next cycle
        launch(1'b0, 5, 0);
        chk("zero_done",  32'(done), 32'd1);
        chk("zero_busy",  32'(busy), 32'd0);
        chk("zero_valid", 32'(out_valid), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(done), 32'd0);
        chk("zero_valid2", 32'(out_valid), 32'd0);

        // count above W is clamped to W beats
        launch(1'b0, 3, W + 5);
        beats = 0; last_idx = -1; seen_done = 1'b0;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            tick();
            if (out_valid) begin
                beats++;
                if (out_last) last_idx = int'(out_index);
            end
            if (done) seen_done = 1'b1;
        end
        chk("clamp_done",  32'(seen_done), 32'd1);
        chk("clamp_beats", 32'(beats), 32'(W));
        chk("clamp_last",  32'(last_idx), 32'd2);
        tick();

        // start while busy is ignored
        launch(1'b0, 1, 3);
        start = 1'b1; col_mode = 1'b1; base = AW'(5); count = (AW+1)'(1);
        tick();
        start = 1'b0;
        expect_beat("busy0", 1, 1'b0, 1'b0);
        chk("busy_op", 32'(read_op), 32'(MAT_DATA_READ_ROW));
        tick(); expect_beat("busy1", 2, 1'b0, 1'b0);
        tick(); expect_beat("busy2", 3, 1'b1, 1'b0);
        tick(); chk("busy_done", 32'(done), 32'd1);
        tick(); chk("busy_idle", 32'(busy), 32'd0);
        chk("busy_nv", 32'(out_valid), 32'd0);

        // Reset mid-stream aborts with no done pulse
        launch(1'b0, 0, 4);
        tick();
        chk("ab_valid_pre", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_busy",  32'(busy), 32'd0);
        chk("ab_op",    32'(read_op), 32'(MAT_DATA_READ_DISABLE));
        tick();
        reset_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done || out_valid) seen_done = 1'b1;
        end
        chk("ab_no_done", 32'(seen_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mat_reg_streamer.md
MAT_REG_STREAMER -- requirements
Module: mat_reg_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 128, the matrix dimension and vector length.
REQ-002 SHALL have parameter WIDTH_ADDR_SIZE, default $clog2(WIDTH), the row/column index width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a transfer; sampled only in IDLE.
REQ-006 SHALL have port col_mode  input  1  0 = stream rows, 1 = stream columns; sampled with start.
REQ-007 SHALL have port base  input  WIDTH_ADDR_SIZE  first row/column index; sampled with start.
REQ-008 SHALL have port count  input  WIDTH_ADDR_SIZE+1  number of vectors, 0..WIDTH; sampled with start.
REQ-009 SHALL have port read_op  output  MatDataReadOp_t  read command to the matrix register.
REQ-010 SHALL have port read_param1  output  WIDTH_ADDR_SIZE  row/column index to the matrix register.
REQ-011 SHALL have port read_param2  output  WIDTH_ADDR_SIZE  tied to 0.
REQ-012 SHALL have port rd_data  input  shortreal[WIDTH]  combinational read data from the matrix register.
REQ-013 SHALL have port out_data  output  shortreal[WIDTH]  registered output vector.
REQ-014 SHALL have port out_index  output  WIDTH_ADDR_SIZE  row/column index of out_data.
REQ-015 SHALL have port out_last  output  1  marks the final vector of a transfer.
REQ-016 SHALL have port out_valid / out_ready  output / input  1 each  downstream valid/ready handshake.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at transfer completion.

Function
REQ-019 SHALL implement states IDLE, STREAM and DRAIN.
REQ-020 IDLE with start=1 and count>0 SHALL latch col_mode, base and count, clear the issue counter k, and go to STREAM.
REQ-021 IDLE with start=1 and count=0 SHALL stay in IDLE, produce no beats, and pulse done on the next cycle.
REQ-022 A read SHALL issue in STREAM when the output slot is free: out_valid=0, or out_valid=1 and out_ready=1.
REQ-023 While issuing, the block SHALL drive read_op = MAT_DATA_READ_COL if col_mode else MAT_DATA_READ_ROW, and read_param1 = (base+k) mod WIDTH, wrapping past WIDTH-1 to 0.
REQ-024 When not issuing, read_op SHALL be MAT_DATA_READ_DISABLE.
REQ-025 An issued read SHALL capture rd_data into out_data at the same edge, set out_valid, set out_index=(base+k) mod WIDTH and out_last=(k==count-1), then increment k.
REQ-026 Latency: start accepted at edge t gives the first read in cycle t+1 and out_valid=1 after edge t+1.
REQ-027 Throughput SHALL be one vector per cycle while out_ready=1.
REQ-028 A beat completes when out_valid and out_ready are both high; out_valid SHALL fall if no new read issues on that edge.
REQ-029 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-030 STREAM SHALL go to DRAIN when the read with k=count-1 issues.
REQ-031 DRAIN SHALL go to IDLE and pulse done in the cycle after the out_last beat completes.
REQ-032 start asserted while busy SHALL be ignored.
REQ-033 count values above WIDTH SHALL be clamped to WIDTH.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state IDLE, k=0, busy=0, done=0, out_valid=0, out_last=0, out_index=0, read_op=MAT_DATA_READ_DISABLE and read_param1=0.
REQ-035 reset_n=0 mid-transfer SHALL abort the transfer with no done pulse; out_data need not be cleared.

Structure
REQ-036 MatDataReadOp_t and its encodings SHALL come from the shared matrix package; no new typedef is needed there.
REQ-037 A local state enum SHALL be defined inside the module.
REQ-038 No sub-module is required; the block SHALL be instantiated beside the matrix register with read_op, read_param1 and read_param2 wired directly.

Verification
REQ-039 Row stream: matrix m[i][j]=i*WIDTH+j, base=2, count=3, out_ready=1 -> beats with index 2,3,4 in consecutive cycles, out_data[j]=m[idx][j], out_last only on index 4, done one cycle after.
REQ-040 Column wrap: col_mode=1, base=WIDTH-2, count=4 -> beat indices WIDTH-2, WIDTH-1, 0, 1 and out_data[i]=m[i][idx].
REQ-041 Backpressure: out_ready held 0 for 5 cycles after the first beat -> beat stable, read_op=MAT_DATA_READ_DISABLE throughout, no beat lost or duplicated on release.
REQ-042 Edge counts: count=0 -> no out_valid and done one cycle after start; count=WIDTH+5 -> exactly WIDTH beats.
REQ-043 Busy start and reset: start pulsed during STREAM -> ignored; reset_n low mid-stream -> out_valid=0 and busy=0 immediately, no done pulse.
